pipeline_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline. It merges four stall sources into one consistent set of pipeline-register write enables and flush strobes:
- load-use hazard
- taken-branch redirect
- multi-cycle MDU op in EX
- data-memory wait states
Sits beside the datapath and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB control. Keeps the state needed for multi-cycle stalls and for redirects that arrive while the pipe is frozen.

---
 rtl/riscv_pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/pipeline_controller.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32 pipeline stall/flush controller.
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned X0_IDX         = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clear_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional perf counters are built only when PIPE_STALL_PERF_EN is defined.
module pipeline_controller
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_MemRead,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mdu_start,
  input  logic                  mdu_done,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  PCwrite,
  output logic                  IF_IDwrite,
  output logic                  ID_EXwrite,
  output logic                  EX_MEMwrite,
  output logic                  MEM_WBwrite,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_flush,
  output logic [CNT_W-1:0]      perf_lu_cnt,
  output logic [CNT_W-1:0]      perf_mdu_cnt,
  output logic [CNT_W-1:0]      perf_mem_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt
);

  pipe_state_e state_q, state_d;
  pipe_state_e ret_state_q, ret_state_d;
  logic        redir_pend_q, redir_pend_d;
  logic        mdu_seen_q, mdu_seen_d;

  logic lu, redir, mem_stall;
  logic run_adv, allow_start, mdu_hold;

  assign lu = ex_MemRead && (ex_rd != REG_ADDR_W'(X0_IDX)) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign redir = ex_branch_taken || redir_pend_q;
  // MEM_WAIT stays frozen until the memory answers, regardless of dmem_req.
  assign mem_stall = (dmem_req && !dmem_ready) || ((state_q == MEM_WAIT) && !dmem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      ret_state_q  <= RUN;
      redir_pend_q <= 1'b0;
      mdu_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_state_q  <= ret_state_d;
      redir_pend_q <= redir_pend_d;
      mdu_seen_q   <= mdu_seen_d;
    end
  end

  always_comb begin
    PCwrite      = 1'b1;
    IF_IDwrite   = 1'b1;
    ID_EXwrite   = 1'b1;
    EX_MEMwrite  = 1'b1;
    MEM_WBwrite  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_flush = 1'b0;
    state_d      = state_q;
    ret_state_d  = ret_state_q;
    redir_pend_d = redir_pend_q;
    mdu_seen_d   = mdu_seen_q;
    run_adv      = 1'b0;
    allow_start  = 1'b0;
    mdu_hold     = 1'b0;

    if (mem_stall) begin
      PCwrite     = 1'b0;
      IF_IDwrite  = 1'b0;
      ID_EXwrite  = 1'b0;
      EX_MEMwrite = 1'b0;
      MEM_WBwrite = 1'b0;
      if (state_q != MEM_WAIT) ret_state_d = state_q;
      state_d = MEM_WAIT;
      if (ex_branch_taken) redir_pend_d = 1'b1;
      if (mdu_done) mdu_seen_d = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          run_adv     = 1'b1;
          allow_start = 1'b1;
        end
        MDU_WAIT: begin
          if (mdu_done) begin
            run_adv = 1'b1;
            state_d = RUN;
          end else begin
            mdu_hold = 1'b1;
          end
        end
        MEM_WAIT: begin
          mdu_seen_d = 1'b0;
          if ((ret_state_q == RUN) || mdu_seen_q) begin
            run_adv = 1'b1;
            state_d = RUN;
          end else begin
            mdu_hold = 1'b1;
            state_d  = MDU_WAIT;
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (run_adv) begin
      if (redir) begin
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        redir_pend_d = 1'b0;
      end else if (lu) begin
        PCwrite     = 1'b0;
        IF_IDwrite  = 1'b0;
        ID_EX_flush = 1'b1;
      end
      if (allow_start && ex_mdu_start && !redir) begin
        PCwrite      = 1'b0;
        IF_IDwrite   = 1'b0;
        ID_EXwrite   = 1'b0;
        EX_MEM_flush = 1'b1;
        state_d      = MDU_WAIT;
      end
    end

    // Hold PC..ID/EX while the MDU works, bubble EX/MEM, let MEM/WB drain.
    if (mdu_hold) begin
      PCwrite      = 1'b0;
      IF_IDwrite   = 1'b0;
      ID_EXwrite   = 1'b0;
      EX_MEM_flush = 1'b1;
    end

    if (reset) begin
      PCwrite      = 1'b0;
      IF_IDwrite   = 1'b0;
      ID_EXwrite   = 1'b0;
      EX_MEMwrite  = 1'b0;
      MEM_WBwrite  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_flush = 1'b1;
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic lu_inc, mdu_inc, mem_inc, flush_inc;

  assign lu_inc    = !reset && run_adv && !redir && lu;
  assign flush_inc = !reset && run_adv && redir;
  assign mdu_inc   = !reset && mdu_hold && (state_q == MDU_WAIT);
  assign mem_inc   = !reset && mem_stall;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_lu (
    .clk(clk), .clear_i(reset), .inc_i(lu_inc), .count_o(perf_lu_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_mdu (
    .clk(clk), .clear_i(reset), .inc_i(mdu_inc), .count_o(perf_mdu_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_mem (
    .clk(clk), .clear_i(reset), .inc_i(mem_inc), .count_o(perf_mem_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk(clk), .clear_i(reset), .inc_i(flush_inc), .count_o(perf_flush_cnt)
  );
`else
  assign perf_lu_cnt    = '0;
  assign perf_mdu_cnt   = '0;
  assign perf_mem_cnt   = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios plus randomized traffic.
module tb_pipeline_controller;

  localparam int M_RUN = 0;
  localparam int M_MDU = 1;
  localparam int M_MEM = 2;

  // Output pattern bits: {PC, IF/ID, ID/EX, EX/MEM, MEM/WB, IF_ID_f, ID_EX_f, EX_MEM_f}
  localparam logic [7:0] P_ADV   = 8'b11111_000;
  localparam logic [7:0] P_REDIR = 8'b11111_110;
  localparam logic [7:0] P_LU    = 8'b00111_010;
  localparam logic [7:0] P_HOLD  = 8'b00011_001;
  localparam logic [7:0] P_FROZE = 8'b00000_000;
  localparam logic [7:0] P_RST   = 8'b00000_111;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_MemRead, ex_branch_taken, ex_mdu_start;
  logic mdu_done, dmem_req, dmem_ready;
  logic PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite;
  logic IF_ID_flush, ID_EX_flush, EX_MEM_flush;
  logic [31:0] perf_lu_cnt, perf_mdu_cnt, perf_mem_cnt, perf_flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int   m_mode = M_RUN;
  int   m_ret  = M_RUN;
  logic m_pend = 1'b0;
  logic m_seen = 1'b0;
  longint c_lu = 0, c_mdu = 0, c_mem = 0, c_fl = 0;

  wire [7:0] act = {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite,
                    IF_ID_flush, ID_EX_flush, EX_MEM_flush};

  pipeline_controller dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_branch_taken(ex_branch_taken),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .ID_EXwrite(ID_EXwrite),
    .EX_MEMwrite(EX_MEMwrite), .MEM_WBwrite(MEM_WBwrite),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
    .perf_lu_cnt(perf_lu_cnt), .perf_mdu_cnt(perf_mdu_cnt),
    .perf_mem_cnt(perf_mem_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [7:0] advance(input logic rd, input logic l, input logic st);
    logic [7:0] r;
    r = rd ? P_REDIR : (l ? P_LU : P_ADV);
    if (st && !rd) r = (r & 8'b0001_1111) | 8'b0000_0001;
    return r;
  endfunction

  function automatic longint sat(input longint v);
    return (v > 64'h0000_0000_FFFF_FFFF) ? 64'h0000_0000_FFFF_FFFF : v;
  endfunction

  // Reference model and per-cycle comparison; model state advances for the next edge.
  always @(negedge clk) begin
    logic [7:0] e;
    logic lu_m, rd_m, stall_m, adv_m, st_m;
    lu_m = ex_MemRead && (ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    rd_m = ex_branch_taken || m_pend;
    stall_m = (dmem_req && !dmem_ready) || (m_mode == M_MEM && !dmem_ready);
    adv_m = 1'b0;
    st_m = 1'b0;
    e = P_FROZE;
    if (reset) begin
      e = P_RST;
    end else if (stall_m) begin
      e = P_FROZE;
    end else if (m_mode == M_RUN) begin
      adv_m = 1'b1;
      st_m = ex_mdu_start;
    end else if (m_mode == M_MDU) begin
      adv_m = mdu_done;
      e = P_HOLD;
    end else begin
      adv_m = (m_ret == M_RUN) || m_seen;
      e = P_HOLD;
    end
    if (adv_m) e = advance(rd_m, lu_m, st_m);
    chk("outputs", 32'(act), 32'(e));

`ifdef PIPE_STALL_PERF_EN
    chk("perf_lu", perf_lu_cnt, 32'(sat(c_lu)));
    chk("perf_mdu", perf_mdu_cnt, 32'(sat(c_mdu)));
    chk("perf_mem", perf_mem_cnt, 32'(sat(c_mem)));
    chk("perf_flush", perf_flush_cnt, 32'(sat(c_fl)));
`else
    chk("perf_tied", perf_lu_cnt | perf_mdu_cnt | perf_mem_cnt | perf_flush_cnt, 32'd0);
`endif

    if (reset) begin
      m_mode = M_RUN; m_ret = M_RUN; m_pend = 1'b0; m_seen = 1'b0;
      c_lu = 0; c_mdu = 0; c_mem = 0; c_fl = 0;
    end else if (stall_m) begin
      if (m_mode != M_MEM) m_ret = m_mode;
      m_mode = M_MEM;
      if (ex_branch_taken) m_pend = 1'b1;
      if (mdu_done) m_seen = 1'b1;
      c_mem++;
    end else begin
      if (adv_m) begin
        if (rd_m) begin m_pend = 1'b0; c_fl++; end
        else if (lu_m) c_lu++;
      end
      if (m_mode == M_MDU && !adv_m) c_mdu++;
      if (m_mode == M_RUN) m_mode = (st_m && !rd_m) ? M_MDU : M_RUN;
      else if (m_mode == M_MDU) m_mode = adv_m ? M_RUN : M_MDU;
      else begin
        m_mode = adv_m ? M_RUN : M_MDU;
        m_seen = 1'b0;
      end
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_MemRead = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] e);
    #3;
    chk(nm, 32'(act), 32'(e));
  endtask

  initial begin
    logic stall_r, bt_ok;
    idle();
    reset = 1'b1;
    #1;
    lit("reset_outputs", P_RST);
    go(); go();
    reset = 1'b0;

    // Load-use on rs2, then the same with ex_rd = x0.
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    lit("load_use", P_LU);
    go(); ex_rd = 5'd0; id_rs2 = 5'd0;
    lit("load_use_x0", P_ADV);
    go(); ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0; ex_branch_taken = 1'b1;
    lit("branch_over_lu", P_REDIR);
    go(); idle();
    lit("run_default", P_ADV);

    // Four-cycle MDU op.
    go(); ex_mdu_start = 1'b1;
    lit("mdu_start", P_HOLD);
    for (int i = 0; i < 3; i++) begin
      go(); ex_mdu_start = 1'b0;
      lit("mdu_hold", P_HOLD);
    end
    go(); mdu_done = 1'b1;
    lit("mdu_done", P_ADV);
    go(); idle();
    lit("after_mdu", P_ADV);

    // Memory wait with a redirect arriving in the first stall cycle.
    go(); dmem_req = 1'b1; ex_branch_taken = 1'b1;
    lit("mem_wait1", P_FROZE);
    go(); ex_branch_taken = 1'b0;
    lit("mem_wait2", P_FROZE);
    go();
    lit("mem_wait3", P_FROZE);
    go(); dmem_ready = 1'b1;
    lit("mem_release_redir", P_REDIR);
    go(); idle();
    lit("pend_cleared", P_ADV);

    // mdu_done lands inside a memory wait entered from MDU_WAIT.
    go(); ex_mdu_start = 1'b1;
    lit("mdu2_start", P_HOLD);
    go(); ex_mdu_start = 1'b0;
    lit("mdu2_hold", P_HOLD);
    go(); dmem_req = 1'b1; mdu_done = 1'b1;
    lit("mdu2_memstall", P_FROZE);
    go(); mdu_done = 1'b0;
    lit("mdu2_memstall2", P_FROZE);
    go(); dmem_ready = 1'b1;
    lit("mdu2_release", P_ADV);
    go(); idle();
    lit("mdu2_run", P_ADV);

    // Reset while waiting on the MDU.
    go(); ex_mdu_start = 1'b1;
    lit("mdu3_start", P_HOLD);
    go(); ex_mdu_start = 1'b0;
    lit("mdu3_hold", P_HOLD);
    go(); reset = 1'b1;
    lit("reset_in_mdu", P_RST);
    go(); reset = 1'b0;
    lit("post_reset_run", P_ADV);

    // Randomized traffic, constrained to sequences a real pipeline can produce.
    for (int n = 0; n < 3000; n++) begin
      go();
      reset = ($urandom_range(0, 199) == 0);
      dmem_req   = (m_mode == M_MEM) ? 1'b1 : ($urandom_range(0, 3) == 0);
      dmem_ready = (m_mode == M_MEM) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
      stall_r = dmem_req && !dmem_ready;
      bt_ok = (m_mode == M_RUN) ||
              (m_mode == M_MEM && (stall_r || m_ret == M_RUN || m_seen));
      ex_branch_taken = bt_ok && ($urandom_range(0, 3) == 0);
      ex_mdu_start = (m_mode == M_RUN) && !stall_r && ($urandom_range(0, 4) == 0);
      mdu_done = (m_mode == M_MDU || (m_mode == M_MEM && m_ret == M_MDU)) &&
                 ($urandom_range(0, 2) == 0);
      ex_MemRead = 1'($urandom_range(0, 1));
      ex_rd  = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
    end

    go(); idle(); reset = 1'b0;
    go();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
